// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, small instruction queue to decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky misalign flag and halt fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    output logic        misalign
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   q_instr_q [QDEPTH];
    logic [31:0]   q_instr_d [QDEPTH];
    logic [31:0]   q_pc_q [QDEPTH];
    logic [31:0]   q_pc_d [QDEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign redirect_tgt = redirect_pc;
    assign misalign     = misalign_q;

    always_comb begin
        misalign_d = misalign_q;
        if (redirect) begin
            misalign_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    // Without the trap, the low address bits are simply discarded on redirect.
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign misalign     = 1'b0;
`endif

    // The credit check here is what guarantees a response never finds the queue full.
    assign imem_req  = (state_q == ST_RUN) && (count_q < QDEPTH_C) && !redirect && !misalign && rst_n;
    assign imem_addr = fetch_pc_q;

    assign id_valid = (count_q != '0);
    assign id_instr = q_instr_q[rd_ptr_q];
    assign id_pc    = q_pc_q[rd_ptr_q];
    assign pop      = id_valid && id_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (imem_req && imem_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    push    = !redirect;
                    state_d = ST_RUN;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_tgt;
        end
    end

    always_comb begin
        q_instr_d = q_instr_q;
        q_pc_d    = q_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (push) begin
            q_instr_d[wr_ptr_q] = imem_rdata;
            q_pc_d[wr_ptr_q]    = req_pc_q;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A flush lets the same-cycle pop complete and then empties whatever is left.
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            // NOTE: queue storage is reset so the decode outputs read zero out of reset.
            for (int i = 0; i < QDEPTH; i++) begin
                q_instr_q[i] <= '0;
                q_pc_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            q_instr_q  <= q_instr_d;
            q_pc_q     <= q_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of memory-latency/stall scenarios plus directed redirect and reset sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        misalign;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_ready    (id_ready),
        .misalign    (misalign)
    );

    typedef struct {
        string       name;
        int          lat;
        bit          slow_gnt;
        int          stall;
        int          n;
        int          gap;
        logic [31:0] pc0;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          mem_lat  = 1;
    bit          slow_gnt = 1'b0;
    int          cyc      = 0;
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    int          got_cyc[$];
    vec_t        vecs[5];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory model: one outstanding request, response mem_lat cycles after the grant cycle.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        bit          pend;
        int          pend_cnt;
        logic [31:0] pend_addr;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_gnt    = 1'b1;
        pend        = 1'b0;
        pend_cnt    = 0;
        pend_addr   = '0;
        forever begin
            @(negedge clk);
            acc      = imem_req && imem_gnt;
            acc_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_gnt    = slow_gnt ? !imem_gnt : 1'b1;
            if (acc) begin
                pend      = 1'b1;
                pend_cnt  = mem_lat - 1;
                pend_addr = acc_addr;
            end
            if (pend) begin
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word_of(pend_addr);
                    pend        = 1'b0;
                end else begin
                    pend_cnt = pend_cnt - 1;
                end
            end
        end
    end

    // Decode-side monitor: records every accepted head entry with its cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (rst_n === 1'b1 && id_valid && id_ready) begin
                got_pc.push_back(id_pc);
                got_instr.push_back(id_instr);
                got_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_dut(input int lat, input bit slow, input logic ready);
        next_cycle();
        rst_n    = 1'b0;
        redirect = 1'b0;
        mem_lat  = lat;
        slow_gnt = slow;
        id_ready = ready;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_id_valid", id_valid, 1'b0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_misalign", misalign, 1'b0);
        next_cycle();
        got_pc.delete();
        got_instr.delete();
        got_cyc.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 300 && got_pc.size() < n; i++) begin
            next_cycle();
        end
        check("pop_count", 32'(got_pc.size()), 32'(n));
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;

        vecs[0] = '{"lat1_stream", 1, 1'b0, 0, 4, 2, 32'h0};
        vecs[1] = '{"lat2_stream", 2, 1'b0, 0, 3, 3, 32'h0};
        vecs[2] = '{"lat3_stream", 3, 1'b0, 0, 3, 4, 32'h0};
        vecs[3] = '{"slow_gnt",    1, 1'b1, 0, 4, 0, 32'h0};
        vecs[4] = '{"stall10",     1, 1'b0, 10, 3, 0, 32'h0};

        foreach (vecs[r]) begin
            reset_dut(vecs[r].lat, vecs[r].slow_gnt, (vecs[r].stall == 0));
            if (vecs[r].stall > 0) begin
                repeat (vecs[r].stall) next_cycle();
                @(negedge clk);
                check({vecs[r].name, "_held_none"}, 32'(got_pc.size()), 32'h0);
                check({vecs[r].name, "_held_valid"}, id_valid, 1'b1);
                check({vecs[r].name, "_held_pc"}, id_pc, vecs[r].pc0);
                check({vecs[r].name, "_held_instr"}, id_instr, word_of(vecs[r].pc0));
                check({vecs[r].name, "_full_noreq"}, imem_req, 1'b0);
                next_cycle();
                id_ready = 1'b1;
            end
            wait_pops(vecs[r].n);
            for (int i = 0; i < vecs[r].n && i < got_pc.size(); i++) begin
                check({vecs[r].name, "_pc"}, got_pc[i], vecs[r].pc0 + 32'(4 * i));
                check({vecs[r].name, "_instr"}, got_instr[i], word_of(vecs[r].pc0 + 32'(4 * i)));
                if (vecs[r].gap > 0 && i > 0) begin
                    check({vecs[r].name, "_gap"}, 32'(got_cyc[i] - got_cyc[i-1]), 32'(vecs[r].gap));
                end
            end
        end

        // Redirect while a 3-cycle request is outstanding: stale word must be dropped.
        reset_dut(3, 1'b0, 1'b1);
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("drop_valid", id_valid, 1'b0);
        check("drop_noreq", imem_req, 1'b0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("drop_stale_gone", id_valid, 1'b0);
        check("drop_req", imem_req, 1'b1);
        check("drop_addr", imem_addr, 32'h100);
        wait_pops(1);
        check("drop_first_pc", got_pc[0], 32'h100);
        check("drop_first_instr", got_instr[0], word_of(32'h100));

        // Redirect coinciding with a response and a pop.
        reset_dut(1, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        next_cycle();
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        check("rp_head_valid", id_valid, 1'b1);
        check("rp_head_pc", id_pc, 32'h0);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("rp_flushed", id_valid, 1'b0);
        check("rp_req", imem_req, 1'b1);
        check("rp_addr", imem_addr, 32'h200);
        wait_pops(2);
        check("rp_popped_pc", got_pc[0], 32'h0);
        check("rp_next_pc", got_pc[1], 32'h200);
        check("rp_next_instr", got_instr[1], word_of(32'h200));

        // Reset during WAIT; the late response lands in RUN and must be ignored.
        reset_dut(3, 1'b0, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("late_req", imem_req, 1'b1);
        check("late_addr", imem_addr, 32'h0);
        check("late_valid0", id_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check("late_ignored", id_valid, 1'b0);
        wait_pops(1);
        check("late_first_pc", got_pc[0], 32'h0);

        // Misaligned redirect target.
        reset_dut(1, 1'b0, 1'b1);
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_flag", misalign, 1'b1);
        check("mis_noreq", imem_req, 1'b0);
        repeat (3) begin
            next_cycle();
            @(negedge clk);
            check("mis_halted", imem_req, 1'b0);
        end
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h104;
        @(negedge clk);
        check("mis_sticky", misalign, 1'b1);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("mis_cleared", misalign, 1'b0);
        check("mis_req", imem_req, 1'b1);
        check("mis_addr", imem_addr, 32'h104);
        wait_pops(1);
        check("mis_first_pc", got_pc[0], 32'h104);
`else
        check("mis_flag", misalign, 1'b0);
        check("mis_valid", id_valid, 1'b0);
        check("mis_req", imem_req, 1'b1);
        check("mis_addr", imem_addr, 32'h100);
        wait_pops(1);
        check("mis_first_pc", got_pc[0], 32'h100);
        check("mis_first_instr", got_instr[0], word_of(32'h100));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
